imemfifo_ctl: RTL and testbench
===============================

Name: imemfifo_ctl

Overview:
- Single-clock FIFO controller that drives a registered-port RAM wrapper (imemrwpx-class) on its write and read ports.
- Accepts a valid/ready input stream and writes it into the RAM.
- Reads entries back, absorbing the RAM's write and read pipeline latency with a small output skid buffer.
- Presents a valid/ready output stream that sustains one word per cycle.

Parameters:
- ADDRBIT, 9, RAM address width.
- DEPTH, 512, RAM entries used, 2..2^ADDRBIT. Need not be a power of two.
- WIDTH, 32, data width.
- WRLAT, 1, cycles from mem_we issue until the entry is readable by a read issued that cycle.
- RDLAT, 2, cycles from mem_re/mem_ra issue until mem_do is valid.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all contents.
- in_vld  in  1  input word valid.
- in_rdy  out  1  input can accept.
- in_dat  in  WIDTH  input word.
- out_vld  out  1  output word valid.
- out_rdy  in  1  consumer accepts.
- out_dat  out  WIDTH  output word.
- level  out  ADDRBIT+2  words held (RAM + in flight + buffer).
- mem_wa  out  ADDRBIT  RAM write address.
- mem_we  out  1  RAM write enable.
- mem_di  out  WIDTH  RAM write data.
- mem_ra  out  ADDRBIT  RAM read address.
- mem_re  out  1  RAM read enable.
- mem_do  in  WIDTH  RAM read data, valid RDLAT cycles after mem_re.

Behaviour:
- Reset state (rst high): all pointers, counters and pipes are 0; out_vld=0, mem_we=0, mem_re=0, level=0, in_rdy=0. After reset deasserts, in_rdy=1.
- Write side:
  - push = in_vld & in_rdy.
  - mem_we = push, mem_wa = wp, mem_di = in_dat, all combinational.
  - wp advances on push and wraps DEPTH-1 -> 0.
- occ counts written, not-yet-read-issued RAM slots:
  - +1 on push, -1 on read issue, both in one cycle gives net 0.
  - in_rdy = (occ != DEPTH) & ~flush.
- Write maturity:
  - Each push enters a WRLAT+1 stage pulse pipe. avail +1 when a pulse exits, -1 on read issue.
  - Reads are issued only when avail>0, so a read never targets an unwritten or in-flight address.
- Read side:
  - BUFD = RDLAT+1 entry output buffer.
  - Issue = (avail>0) & (outstanding + bufcnt - pop < BUFD), where pop = out_vld & out_rdy.
  - mem_re = issue, mem_ra = rp. rp advances and wraps like wp.
  - A RDLAT-stage pulse pipe marks return. On pulse exit, mem_do is written into the buffer tail and outstanding decrements.
- Output:
  - out_vld = bufcnt != 0, out_dat = buffer head, both registered.
  - Pop and return in the same cycle are both honoured. The buffer never overflows (credit rule).
- level = occ + (avail-pipe pulses in flight are already in occ) + outstanding + bufcnt. Maximum DEPTH+BUFD.
- Ordering: strict FIFO.
- Throughput: 1 word/cycle sustained when in_vld and out_rdy are held high.
- Latency: push at cycle t -> out_vld at t+WRLAT+RDLAT+2 (5 with defaults) into an empty FIFO.
- flush:
  - Next cycle: wp=rp=0, occ=avail=outstanding=bufcnt=0, all pulse pipes cleared, out_vld=0, level=0.
  - Returning mem_do is discarded. No push is accepted in the flush cycle.
  - mem_re is not asserted in the flush cycle.
- out_rdy is ignored when out_vld=0. in_dat is ignored when push=0.

Test Plan:
- Latency: after reset, one push of 0xA5A5A5A5 at cycle 0, out_rdy=1 -> mem_we at cycle 0, mem_re at cycle 2 with mem_ra=0, out_vld at cycle 5 with out_dat=0xA5A5A5A5. level goes 1 -> 0 after the pop.
- Streaming: 1000 words 0..999 with in_vld=out_rdy=1 continuously -> in_rdy never drops, outputs 0..999 in order, one per cycle after the first at cycle 5.
- Full:
  - Push with out_rdy=0 -> after DEPTH+BUFD=515 pushes, in_rdy=0 and level=515.
  - One pop -> in_rdy returns to 1 within 1 cycle.
  - Pointers wrap 511 -> 0 with no data loss.
- Backpressure: random out_rdy (50%) and random in_vld -> scoreboard shows no loss, no duplication, order kept. The buffer never exceeds 3.
- Flush: flush asserted with 10 words held and 2 reads outstanding -> next cycle level=0 and out_vld=0. Returning data is dropped. A following push of 0x1 emerges first, at +5 cycles.
- Reset mid-operation: rst asserted asynchronously mid-stream -> outputs go to 0 immediately. After release, in_rdy=1 and level=0.

Source files
------------

// File: rtl/imemfifo_ctl.sv
// FIFO controller in front of a registered-port RAM: valid/ready in, valid/ready out,
// with a small skid buffer sized to cover the RAM read latency (WRLAT, RDLAT >= 1).
module imemfifo_ctl #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32,
    parameter int WRLAT   = 1,
    parameter int RDLAT   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [WIDTH-1:0]   in_dat,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [WIDTH-1:0]   out_dat,
    output logic [ADDRBIT+1:0] level,
    output logic [ADDRBIT-1:0] mem_wa,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_di,
    output logic [ADDRBIT-1:0] mem_ra,
    output logic               mem_re,
    input  logic [WIDTH-1:0]   mem_do
);
    localparam int BUFD = RDLAT + 1;
    localparam int CW   = $clog2(BUFD + 1);
    localparam int OW   = ADDRBIT + 1;
    localparam int LW   = ADDRBIT + 2;
    localparam logic [ADDRBIT-1:0] LAST_A  = ADDRBIT'(DEPTH - 1);
    localparam logic [OW-1:0]      DEPTH_C = OW'(DEPTH);
    localparam logic [CW:0]        BUFD_C  = (CW + 1)'(BUFD);

    logic [ADDRBIT-1:0] wp_r, rp_r, wp_n, rp_n;
    logic [OW-1:0]      occ_r, avail_r, occ_n, avail_n;
    logic [WRLAT-1:0]   wpipe_r, wpipe_n;
    logic [RDLAT-1:0]   rpipe_r, rpipe_n;
    logic [CW-1:0]      outst_r, bufcnt_r, outst_n, bufcnt_n, widx_s;
    logic [CW:0]        inuse_s;
    logic [WIDTH-1:0]   bufm_r [BUFD];
    logic [WIDTH-1:0]   buf_n  [BUFD];
    logic               out_vld_r;
    logic [WIDTH-1:0]   out_dat_r;
    logic [LW-1:0]      level_r, level_n;
    logic               push_s, pop_s, issue_s, ret_s, wexit_s;

    // Handshakes, RAM port drive and read-credit decision.
    always_comb begin
        in_rdy  = (occ_r != DEPTH_C) & ~flush & ~rst;
        push_s  = in_vld & in_rdy;
        pop_s   = out_vld_r & out_rdy;
        wexit_s = wpipe_r[WRLAT-1];
        ret_s   = rpipe_r[RDLAT-1];
        // Reads in flight plus buffered words, after this cycle's pop, must leave a free slot.
        inuse_s = (CW + 1)'(outst_r) + (CW + 1)'(bufcnt_r) - (CW + 1)'(pop_s);
        issue_s = (avail_r != {OW{1'b0}}) & (inuse_s < BUFD_C) & ~flush;
        mem_we  = push_s;
        mem_wa  = wp_r;
        mem_di  = in_dat;
        mem_re  = issue_s;
        mem_ra  = rp_r;
    end

    // Next-state computation for pointers, counters, pulse pipes and the skid buffer.
    always_comb begin
        if (push_s) begin
            wp_n = (wp_r == LAST_A) ? {ADDRBIT{1'b0}} : wp_r + ADDRBIT'(1);
        end else begin
            wp_n = wp_r;
        end
        if (issue_s) begin
            rp_n = (rp_r == LAST_A) ? {ADDRBIT{1'b0}} : rp_r + ADDRBIT'(1);
        end else begin
            rp_n = rp_r;
        end
        occ_n    = occ_r + OW'(push_s) - OW'(issue_s);
        avail_n  = avail_r + OW'(wexit_s) - OW'(issue_s);
        outst_n  = outst_r + CW'(issue_s) - CW'(ret_s);
        bufcnt_n = bufcnt_r + CW'(ret_s) - CW'(pop_s);
        wpipe_n    = wpipe_r << 1'b1;
        wpipe_n[0] = push_s;
        rpipe_n    = rpipe_r << 1'b1;
        rpipe_n[0] = issue_s;
        // Head lives at index 0 so out_dat is a plain register copy of it.
        if (pop_s) begin
            for (int i = 0; i < BUFD - 1; i++) begin
                buf_n[i] = bufm_r[i + 1];
            end
            buf_n[BUFD-1] = bufm_r[BUFD-1];
        end else begin
            for (int i = 0; i < BUFD; i++) begin
                buf_n[i] = bufm_r[i];
            end
        end
        widx_s = bufcnt_r - CW'(pop_s);
        for (int i = 0; i < BUFD; i++) begin
            if (ret_s && (widx_s == CW'(i))) begin
                buf_n[i] = mem_do;
            end else begin
                buf_n[i] = buf_n[i];
            end
        end
        level_n = LW'(occ_n) + LW'(outst_n) + LW'(bufcnt_n);
    end

    // State registers with asynchronous reset and synchronous flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r      <= {ADDRBIT{1'b0}};
            rp_r      <= {ADDRBIT{1'b0}};
            occ_r     <= {OW{1'b0}};
            avail_r   <= {OW{1'b0}};
            wpipe_r   <= {WRLAT{1'b0}};
            rpipe_r   <= {RDLAT{1'b0}};
            outst_r   <= {CW{1'b0}};
            bufcnt_r  <= {CW{1'b0}};
            out_vld_r <= 1'b0;
            out_dat_r <= {WIDTH{1'b0}};
            level_r   <= {LW{1'b0}};
            for (int i = 0; i < BUFD; i++) bufm_r[i] <= {WIDTH{1'b0}};
        end else if (flush) begin
            wp_r      <= {ADDRBIT{1'b0}};
            rp_r      <= {ADDRBIT{1'b0}};
            occ_r     <= {OW{1'b0}};
            avail_r   <= {OW{1'b0}};
            wpipe_r   <= {WRLAT{1'b0}};
            rpipe_r   <= {RDLAT{1'b0}};
            outst_r   <= {CW{1'b0}};
            bufcnt_r  <= {CW{1'b0}};
            out_vld_r <= 1'b0;
            out_dat_r <= {WIDTH{1'b0}};
            level_r   <= {LW{1'b0}};
            for (int i = 0; i < BUFD; i++) bufm_r[i] <= {WIDTH{1'b0}};
        end else begin
            wp_r      <= wp_n;
            rp_r      <= rp_n;
            occ_r     <= occ_n;
            avail_r   <= avail_n;
            wpipe_r   <= wpipe_n;
            rpipe_r   <= rpipe_n;
            outst_r   <= outst_n;
            bufcnt_r  <= bufcnt_n;
            out_vld_r <= (bufcnt_n != {CW{1'b0}});
            out_dat_r <= buf_n[0];
            level_r   <= level_n;
            for (int i = 0; i < BUFD; i++) bufm_r[i] <= buf_n[i];
        end
    end

    assign out_vld = out_vld_r;
    assign out_dat = out_dat_r;
    assign level   = level_r;
endmodule

// File: tb/tb_imemfifo_ctl.sv
// Bench for imemfifo_ctl with a registered-port RAM model (write 1, read 2 cycles)
// and a queue scoreboard on the output stream.
module tb_imemfifo_ctl;
    logic        clk = 1'b0;
    logic        rst, flush, in_vld, in_rdy, out_vld, out_rdy, mem_we, mem_re;
    logic [31:0] in_dat, out_dat, mem_di, mem_do;
    logic [10:0] level;
    logic [8:0]  mem_wa, mem_ra;

    imemfifo_ctl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
        .level(level),
        .mem_wa(mem_wa), .mem_we(mem_we), .mem_di(mem_di),
        .mem_ra(mem_ra), .mem_re(mem_re), .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    // RAM model: address registered, then data registered.
    logic [31:0] ram [512];
    logic [8:0]  ra_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_wa] <= mem_di;
        ra_q   <= mem_ra;
        mem_do <= ram[ra_q];
    end

    int checks = 0, failures = 0;
    int cyc_n = 0, npop = 0, first_pop = -1, last_pop = -1;
    bit pushed;
    logic [31:0] q[$];

    typedef struct {
        logic v; logic [31:0] d; logic r;
        logic e_we; logic e_re; logic [8:0] e_ra;
        logic e_ov; logic [31:0] e_od; logic [10:0] e_lv;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_vld = v; in_dat = d; out_rdy = r; flush = f;
        #1;
    endtask

    // Score the current cycle's handshakes, then advance to just after the next edge.
    task automatic step();
        pushed = 1'b0;
        if (out_vld && out_rdy) begin
            if (q.size() == 0) chk("sb_unexpected_pop", 64'd1, 64'd0);
            else chk("sb_data", {32'h0, out_dat}, {32'h0, q.pop_front()});
            npop++;
            if (first_pop < 0) first_pop = cyc_n;
            last_pop = cyc_n;
        end
        if (flush) q.delete();
        if (in_vld && in_rdy) begin
            q.push_back(in_dat);
            pushed = 1'b1;
        end
        @(posedge clk); #1;
        cyc_n++;
    endtask

    initial begin
        int nxt, drops, first_push, k, ovbad;
        tv[0] = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 32'h0, 11'd0};
        tv[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 32'h0, 11'd1};
        tv[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 9'd0, 1'b0, 32'h0, 11'd1};
        tv[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 9'd1, 1'b0, 32'h0, 11'd1};
        tv[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 9'd1, 1'b0, 32'h0, 11'd1};
        tv[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 9'd1, 1'b1, 32'hA5A5A5A5, 11'd1};
        tv[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 9'd1, 1'b0, 32'h0, 11'd0};

        // Reset state
        rst = 1'b1; in_vld = 1'b1; in_dat = 32'h0; out_rdy = 1'b1; flush = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_rdy", {63'h0, in_rdy}, 64'd0);
        chk("rst_out_vld", {63'h0, out_vld}, 64'd0);
        chk("rst_level", {53'h0, level}, 64'd0);
        chk("rst_mem_we", {63'h0, mem_we}, 64'd0);
        chk("rst_mem_re", {63'h0, mem_re}, 64'd0);
        @(posedge clk); #1;
        in_vld = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_in_rdy", {63'h0, in_rdy}, 64'd1);
        @(posedge clk); #1;

        // Single-word latency, table driven
        for (int i = 0; i < 7; i++) begin
            drive(tv[i].v, tv[i].d, tv[i].r, 1'b0);
            chk($sformatf("lat%0d_in_rdy", i), {63'h0, in_rdy}, 64'd1);
            chk($sformatf("lat%0d_mem_we", i), {63'h0, mem_we}, {63'h0, tv[i].e_we});
            chk($sformatf("lat%0d_mem_re", i), {63'h0, mem_re}, {63'h0, tv[i].e_re});
            chk($sformatf("lat%0d_mem_ra", i), {55'h0, mem_ra}, {55'h0, tv[i].e_ra});
            chk($sformatf("lat%0d_out_vld", i), {63'h0, out_vld}, {63'h0, tv[i].e_ov});
            if (tv[i].e_ov) chk($sformatf("lat%0d_out_dat", i), {32'h0, out_dat}, {32'h0, tv[i].e_od});
            chk($sformatf("lat%0d_level", i), {53'h0, level}, {53'h0, tv[i].e_lv});
            step();
        end

        // Streaming 1000 words
        nxt = 0; drops = 0; first_push = cyc_n; npop = 0; first_pop = -1;
        for (int c = 0; c < 1100 && nxt < 1000; c++) begin
            drive(1'b1, nxt, 1'b1, 1'b0);
            if (!in_rdy) drops++;
            step();
            if (pushed) nxt++;
        end
        for (int c = 0; c < 50 && q.size() > 0; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
        end
        chk("stream_in_rdy_drops", drops, 64'd0);
        chk("stream_npop", npop, 64'd1000);
        chk("stream_first_latency", first_pop - first_push, 64'd5);
        chk("stream_back_to_back", last_pop - first_pop, 64'd999);

        // Fill to capacity with the consumer stalled
        k = 0;
        for (int c = 0; c < 600; c++) begin
            drive(1'b1, 32'h10000 + k, 1'b0, 1'b0);
            if (!in_rdy) break;
            step();
            if (pushed) k++;
        end
        chk("full_pushes", k, 64'd515);
        chk("full_level", {53'h0, level}, 64'd515);
        chk("full_in_rdy", {63'h0, in_rdy}, 64'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_in_rdy_after_pop", {63'h0, in_rdy}, 64'd1);
        npop = 0;
        for (int c = 0; c < 700 && q.size() > 0; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
        end
        chk("full_drained", npop, 64'd514);

        // Random backpressure
        nxt = 32'h20000;
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom % 2), nxt, 1'($urandom % 2), 1'b0);
            step();
            if (pushed) nxt++;
        end
        for (int c = 0; c < 700 && q.size() > 0; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
        end
        chk("rand_queue_empty", q.size(), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rand_level_zero", {53'h0, level}, 64'd0);

        // Flush with 10 words held and 2 reads outstanding
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 32'h30000 + c, 1'b0, 1'b0);
            step();
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
        chk("flush_level_before", {53'h0, level}, 64'd10);
        chk("flush_in_rdy", {63'h0, in_rdy}, 64'd0);
        chk("flush_mem_re", {63'h0, mem_re}, 64'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_level_after", {53'h0, level}, 64'd0);
        chk("flush_out_vld_after", {63'h0, out_vld}, 64'd0);
        ovbad = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            if (out_vld) ovbad++;
            step();
        end
        chk("flush_return_dropped", ovbad, 64'd0);
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        chk("flush_push_wa", {55'h0, mem_wa}, 64'd0);
        step();
        k = 1;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            if (out_vld) break;
            step();
            k++;
        end
        chk("flush_next_latency", k, 64'd5);
        chk("flush_next_data", {32'h0, out_dat}, 64'd1);
        step();

        // Asynchronous reset mid-stream
        nxt = 32'h40000;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, nxt, 1'b1, 1'b0);
            step();
            if (pushed) nxt++;
        end
        drive(1'b1, nxt, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_vld", {63'h0, out_vld}, 64'd0);
        chk("arst_level", {53'h0, level}, 64'd0);
        chk("arst_in_rdy", {63'h0, in_rdy}, 64'd0);
        chk("arst_mem_we", {63'h0, mem_we}, 64'd0);
        chk("arst_mem_re", {63'h0, mem_re}, 64'd0);
        q.delete();
        in_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_release_in_rdy", {63'h0, in_rdy}, 64'd1);
        chk("arst_release_level", {53'h0, level}, 64'd0);
        ovbad = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            if (out_vld) ovbad++;
            step();
        end
        chk("arst_no_stale_output", ovbad, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
